sync_mc_fifo: RTL and testbench
===============================

// Module: sync_mc_fifo
// PURPOSE
// - Multi-channel synchronous FIFO: NUM_CH independent queues in one statically partitioned storage array, one write and one read port, each steered by a channel index.
// - Successor to the single-channel sync FIFO. Adds per-channel status, non-power-of-2 depth, clearable sticky error flags and an optional per-channel high-water mark.
// - Used as the buffer between a channelised producer and an arbitrating consumer inside one clock domain.
// PARAMETERS
// - DATA_WIDTH   8          data bits per entry
// - NUM_CH       4          number of channels, >=1
// - CH_DEPTH     6          entries per channel, >=2, any integer
// - AFULL_LVL    CH_DEPTH-1 almost_full[c]  = cnt[c] >= AFULL_LVL
// - AEMPTY_LVL   1          almost_empty[c] = cnt[c] <= AEMPTY_LVL
// - RDATA_MODE   0          0: combinational rd_data; 1: registered rd_data
// - Derived: CH_W = max(1,$clog2(NUM_CH)), AW = max(1,$clog2(CH_DEPTH)), CW = $clog2(CH_DEPTH+1)
// PORTS
// - clk           in   1              clock, rising edge
// - rst           in   1              asynchronous reset, active-high
// - wr_en         in   1              write request
// - wr_ch         in   CH_W           write channel index
// - wr_data       in   DATA_WIDTH     write data
// - rd_en         in   1              read request
// - rd_ch         in   CH_W           read channel index
// - rd_data       out  DATA_WIDTH     read data
// - rd_valid      out  1              rd_data qualifier
// - flag_clr      in   1              clears all sticky flags (and watermarks)
// - full          out  NUM_CH         per-channel full
// - empty         out  NUM_CH         per-channel empty
// - almost_full   out  NUM_CH         per-channel almost full
// - almost_empty  out  NUM_CH         per-channel almost empty
// - cnt           out  NUM_CH*CW      per-channel occupancy; channel c sits at [c*CW +: CW]
// - overflow      out  NUM_CH         sticky: write attempted while that channel is full
// - underflow     out  NUM_CH         sticky: read attempted while that channel is empty
// - ch_err        out  1              sticky: wr_ch or rd_ch >= NUM_CH while its enable is set
// BEHAVIOUR
// - Reset: all pointers, cnt, overflow, underflow, ch_err and rd_valid are 0. rd_data is 0 when RDATA_MODE=1. The storage array is not reset.
// - Reset values of the status outputs: empty all 1; full all 0; almost_empty all 1 (AEMPTY_LVL>=0); almost_full follows AFULL_LVL.
// - Reset asserted mid-operation discards all contents immediately.
// - Accept conditions:
//   - wr_ok = wr_en & wr_ch<NUM_CH & ~full[wr_ch]
//   - rd_ok = rd_en & rd_ch<NUM_CH & ~empty[rd_ch]
//   - Both are evaluated on pre-edge state.
// - Storage: entry address is ch*CH_DEPTH + ptr. Each per-channel pointer wraps from CH_DEPTH-1 to 0, with no power-of-2 assumption.
// - Same channel, wr_ok & rd_ok in one cycle: cnt unchanged, both pointers advance.
// - Empty channel, write and read in the same cycle: the write is accepted, the read is rejected and underflow is set. Data is never bypassed.
// - Full channel, write and read in the same cycle: the read is accepted, the write is rejected and overflow is set.
// - Different channels, write and read in the same cycle: fully independent.
// - RDATA_MODE=0: rd_data = mem[rd_ch head], combinationally. rd_valid = ~empty[rd_ch] when rd_ch is legal, else 0.
// - RDATA_MODE=1: rd_data is registered on rd_ok. rd_valid pulses for 1 cycle, one cycle after rd_ok. rd_data holds its value otherwise.
// - Sticky flags set on the edge after the offending request and stay set until flag_clr or rst.
// - flag_clr together with a new error in the same cycle: the flag is set (set wins).
// - Illegal channel index: the request is a no-op, ch_err is set, no per-channel flag changes.
// - cnt is CW bits wide and saturates at neither end; the accept gating guarantees 0..CH_DEPTH.
// CONFIGURATION
// - Macro SYNC_MC_FIFO_WATERMARK_EN.
// - Defined: adds output watermark [NUM_CH*CW] = maximum cnt reached per channel since reset or flag_clr. It updates on the edge where cnt rises, and flag_clr loads the current cnt.
// - Undefined: port and logic are absent; all other behaviour is identical.
// STRUCTURE
// - Package sync_mc_fifo_pkg holds:
//   - the CH_W/AW/CW width functions
//   - the channel-slice helper (c*CW)
//   - the RDATA_MODE encodings RD_COMB=0 and RD_REG=1
// - Sub-module sync_mc_fifo_ch is instantiated NUM_CH times via generate. Each instance holds one channel's wr_ptr, rd_ptr, cnt, flags and the optional watermark, with inputs wr_ok_c, rd_ok_c, wr_try_c, rd_try_c and flag_clr.
// - Top level contains channel decode, the shared storage array and the read mux/register.
// TESTING
// - Write 6 words 0x10..0x15 to ch2 (CH_DEPTH=6) -> full[2]=1, cnt[2]=6, other channels remain empty.
// - 7th write to ch2 -> ignored, overflow[2]=1 next cycle. Reading 6 words gives 0x10..0x15 in order; underflow[2]=0.
// - Interleave writes to ch0/ch3 and wrap each channel twice -> per-channel order preserved, no cross-channel corruption.
// - Empty ch1, wr_en and rd_en on ch1 in the same cycle -> cnt[1]=1, underflow[1]=1. flag_clr -> underflow[1]=0.
// - RDATA_MODE=1, read ch0 holding 0xA5 -> rd_valid=1 and rd_data=0xA5 exactly one cycle later. rst mid-burst -> all empty, rd_valid=0.
// - rd_ch=NUM_CH (NUM_CH=5) with rd_en -> ch_err=1, all cnt unchanged. WATERMARK_EN: fill ch0 to 4, drain to 0 -> watermark[0]=4.

Source files
------------

// File: rtl/sync_mc_fifo_pkg.sv
// Shared definitions for the multi-channel synchronous FIFO.
// Contents: derived-width helpers, the per-channel packed-slice helper and
// the rd_data mode encodings. No ports.
package sync_mc_fifo_pkg;

  localparam int unsigned RD_COMB = 0;
  localparam int unsigned RD_REG  = 1;

  // Channel index width, never narrower than 1 bit.
  function automatic int unsigned calc_ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  // Pointer/address width for a given depth, never narrower than 1 bit.
  function automatic int unsigned calc_aw(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width: must represent 0..depth inclusive.
  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // LSB of channel c inside a packed per-channel vector of w-bit fields.
  function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/sync_mc_fifo_ch.sv
// One channel's bookkeeping for sync_mc_fifo: read/write pointers, occupancy,
// status decode, sticky overflow/underflow and the optional high-water mark.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   wr_ok_c, rd_ok_c  accepted write / read on this channel
//   wr_try_c, rd_try_c  write / read requested on this channel (legal index)
//   flag_clr          clear sticky flags (and watermark)
//   wr_ptr, rd_ptr    channel-local storage pointers
//   cnt               occupancy 0..CH_DEPTH
//   full, empty, almost_full, almost_empty  status
//   watermark         max cnt since reset/flag_clr (SYNC_MC_FIFO_WATERMARK_EN)
//   overflow, underflow  sticky error flags
module sync_mc_fifo_ch
  import sync_mc_fifo_pkg::*;
#(
  parameter int unsigned CH_DEPTH   = 6,
  parameter int unsigned AFULL_LVL  = CH_DEPTH - 1,
  parameter int unsigned AEMPTY_LVL = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_ok_c,
  input  logic                           rd_ok_c,
  input  logic                           wr_try_c,
  input  logic                           rd_try_c,
  input  logic                           flag_clr,
  output logic [calc_aw(CH_DEPTH)-1:0]   wr_ptr,
  output logic [calc_aw(CH_DEPTH)-1:0]   rd_ptr,
  output logic [calc_cw(CH_DEPTH)-1:0]   cnt,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
`ifdef SYNC_MC_FIFO_WATERMARK_EN
  output logic [calc_cw(CH_DEPTH)-1:0]   watermark,
`endif
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned AW = calc_aw(CH_DEPTH);
  localparam int unsigned CW = calc_cw(CH_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(CH_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_LVL);
  localparam logic [AW-1:0] LAST_C  = AW'(CH_DEPTH - 1);

  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (wr_ok_c && !rd_ok_c)
      cnt_next = cnt + 1'b1;
    else if (rd_ok_c && !wr_ok_c)
      cnt_next = cnt - 1'b1;
  end

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Explicit wrap compare: depth need not be a power of two.
      if (wr_ok_c) wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
      if (rd_ok_c) rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
      cnt <= cnt_next;
      // A new error in the clearing cycle still sets the flag.
      overflow  <= (overflow  & ~flag_clr) | (wr_try_c & full);
      underflow <= (underflow & ~flag_clr) | (rd_try_c & empty);
    end
  end

`ifdef SYNC_MC_FIFO_WATERMARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      watermark <= '0;
    else if (flag_clr)
      // Restart from the current level, keeping a rise in the same cycle.
      watermark <= (cnt_next > cnt) ? cnt_next : cnt;
    else if (cnt_next > watermark)
      watermark <= cnt_next;
  end
`endif

endmodule

// File: rtl/sync_mc_fifo.sv
// Multi-channel synchronous FIFO: NUM_CH independent queues statically
// partitioned in one storage array, one write and one read port steered by
// channel index. Optional per-channel high-water mark under the macro
// SYNC_MC_FIFO_WATERMARK_EN.
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   wr_en, wr_ch, wr_data    write request, channel, data
//   rd_en, rd_ch             read request, channel
//   rd_data, rd_valid        read data and qualifier (comb or registered)
//   flag_clr                 clear sticky flags and watermarks
//   full, empty, almost_full, almost_empty  per-channel status
//   cnt                      per-channel occupancy, channel c at [c*CW +: CW]
//   watermark                per-channel max occupancy (macro only)
//   overflow, underflow      per-channel sticky errors
//   ch_err                   sticky illegal-channel error
module sync_mc_fifo
  import sync_mc_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_DEPTH   = 6,
  parameter int unsigned AFULL_LVL  = CH_DEPTH - 1,
  parameter int unsigned AEMPTY_LVL = 1,
  parameter int unsigned RDATA_MODE = RD_COMB
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [calc_ch_w(NUM_CH)-1:0]          wr_ch,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  rd_en,
  input  logic [calc_ch_w(NUM_CH)-1:0]          rd_ch,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  rd_valid,
  input  logic                                  flag_clr,
  output logic [NUM_CH-1:0]                     full,
  output logic [NUM_CH-1:0]                     empty,
  output logic [NUM_CH-1:0]                     almost_full,
  output logic [NUM_CH-1:0]                     almost_empty,
  output logic [NUM_CH*calc_cw(CH_DEPTH)-1:0]   cnt,
  output logic [NUM_CH-1:0]                     overflow,
  output logic [NUM_CH-1:0]                     underflow,
`ifdef SYNC_MC_FIFO_WATERMARK_EN
  output logic [NUM_CH*calc_cw(CH_DEPTH)-1:0]   watermark,
`endif
  output logic                                  ch_err
);

  localparam int unsigned CH_W  = calc_ch_w(NUM_CH);
  localparam int unsigned AW    = calc_aw(CH_DEPTH);
  localparam int unsigned CW    = calc_cw(CH_DEPTH);
  localparam int unsigned MEM_N = NUM_CH * CH_DEPTH;
  localparam int unsigned MA_W  = calc_aw(MEM_N);

  logic [DATA_WIDTH-1:0] mem [MEM_N];
  logic [AW-1:0]         wr_ptr_a [NUM_CH];
  logic [AW-1:0]         rd_ptr_a [NUM_CH];
  logic [NUM_CH-1:0]     wr_sel, rd_sel;
  logic [AW-1:0]         wr_ptr_s, rd_ptr_s;
  logic                  full_s, empty_s;
  logic                  wr_legal, rd_legal, wr_ok, rd_ok;
  logic [MA_W-1:0]       wr_addr, rd_addr;

  // One-hot channel decode; an index >= NUM_CH matches nothing, which is
  // exactly the illegal-channel condition.
  always_comb begin
    wr_sel   = '0;
    rd_sel   = '0;
    wr_ptr_s = '0;
    rd_ptr_s = '0;
    full_s   = 1'b0;
    empty_s  = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CH_W'(c)) begin
        wr_sel[c] = 1'b1;
        wr_ptr_s  = wr_ptr_a[c];
        full_s    = full[c];
      end
      if (rd_ch == CH_W'(c)) begin
        rd_sel[c] = 1'b1;
        rd_ptr_s  = rd_ptr_a[c];
        empty_s   = empty[c];
      end
    end
    wr_legal = |wr_sel;
    rd_legal = |rd_sel;
    wr_ok    = wr_en & wr_legal & ~full_s;
    rd_ok    = rd_en & rd_legal & ~empty_s;
    wr_addr  = MA_W'(32'(wr_ch) * CH_DEPTH + 32'(wr_ptr_s));
    rd_addr  = MA_W'(32'(rd_ch) * CH_DEPTH + 32'(rd_ptr_s));
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ch_err <= 1'b0;
    else
      ch_err <= (ch_err & ~flag_clr) | (wr_en & ~wr_legal) | (rd_en & ~rd_legal);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_mc_fifo_ch #(
      .CH_DEPTH   (CH_DEPTH),
      .AFULL_LVL  (AFULL_LVL),
      .AEMPTY_LVL (AEMPTY_LVL)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr_ok_c      (wr_ok & wr_sel[c]),
      .rd_ok_c      (rd_ok & rd_sel[c]),
      .wr_try_c     (wr_en & wr_sel[c]),
      .rd_try_c     (rd_en & rd_sel[c]),
      .flag_clr     (flag_clr),
      .wr_ptr       (wr_ptr_a[c]),
      .rd_ptr       (rd_ptr_a[c]),
      .cnt          (cnt[ch_lsb(c, CW) +: CW]),
      .full         (full[c]),
      .empty        (empty[c]),
      .almost_full  (almost_full[c]),
      .almost_empty (almost_empty[c]),
`ifdef SYNC_MC_FIFO_WATERMARK_EN
      .watermark    (watermark[ch_lsb(c, CW) +: CW]),
`endif
      .overflow     (overflow[c]),
      .underflow    (underflow[c])
    );
  end

  if (RDATA_MODE == RD_REG) begin : g_rd_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) rd_data <= mem[rd_addr];
      end
    end
  end else begin : g_rd_comb
    always_comb begin
      rd_data  = mem[rd_addr];
      rd_valid = rd_legal & ~empty_s;
    end
  end

endmodule

// File: tb/tb_sync_mc_fifo.sv
// Self-checking bench for sync_mc_fifo. Two instances run side by side:
//   A: NUM_CH=4, CH_DEPTH=6, default levels, combinational rd_data
//   B: NUM_CH=5, CH_DEPTH=5, AFULL_LVL=3, AEMPTY_LVL=2, registered rd_data
// Both are compared every cycle against a queue-based reference model.
module tb_sync_mc_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic       a_wr_en, a_rd_en, a_flag_clr, a_rd_valid, a_ch_err;
  logic [1:0] a_wr_ch, a_rd_ch;
  logic [7:0] a_wr_data, a_rd_data;
  logic [3:0] a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [11:0] a_cnt;

  logic       b_wr_en, b_rd_en, b_flag_clr, b_rd_valid, b_ch_err;
  logic [2:0] b_wr_ch, b_rd_ch;
  logic [7:0] b_wr_data, b_rd_data;
  logic [4:0] b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [14:0] b_cnt;
`ifdef SYNC_MC_FIFO_WATERMARK_EN
  logic [11:0] a_wm;
  logic [14:0] b_wm;
`endif

  sync_mc_fifo #(
    .DATA_WIDTH(8), .NUM_CH(4), .CH_DEPTH(6), .AFULL_LVL(5), .AEMPTY_LVL(1), .RDATA_MODE(0)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_ch(a_wr_ch), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_ch(a_rd_ch), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
    .flag_clr(a_flag_clr), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .cnt(a_cnt), .overflow(a_ovf), .underflow(a_unf),
`ifdef SYNC_MC_FIFO_WATERMARK_EN
    .watermark(a_wm),
`endif
    .ch_err(a_ch_err)
  );

  sync_mc_fifo #(
    .DATA_WIDTH(8), .NUM_CH(5), .CH_DEPTH(5), .AFULL_LVL(3), .AEMPTY_LVL(2), .RDATA_MODE(1)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_ch(b_rd_ch), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .flag_clr(b_flag_clr), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .cnt(b_cnt), .overflow(b_ovf), .underflow(b_unf),
`ifdef SYNC_MC_FIFO_WATERMARK_EN
    .watermark(b_wm),
`endif
    .ch_err(b_ch_err)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned nch(input int d);  return (d == 0) ? 4 : 5; endfunction
  function automatic int unsigned dep(input int d);  return (d == 0) ? 6 : 5; endfunction
  function automatic int unsigned afl(input int d);  return (d == 0) ? 5 : 3; endfunction
  function automatic int unsigned ael(input int d);  return (d == 0) ? 1 : 2; endfunction

  // Stimulus for the next cycle, per instance.
  bit          s_wen[2], s_ren[2], s_clr[2];
  int unsigned s_wch[2], s_rch[2];
  logic [7:0]  s_wd[2];

  // Reference model.
  typedef logic [7:0] byte_q_t[$];
  byte_q_t     q[2][5];
  bit          m_ovf[2][5], m_unf[2][5], m_cerr[2];
  int unsigned m_wm[2][5];
  bit          m_rv;
  logic [7:0]  m_rd;

  task automatic set_wr(input int d, input int unsigned ch, input logic [7:0] dat);
    s_wen[d] = 1'b1; s_wch[d] = ch; s_wd[d] = dat;
  endtask

  task automatic set_rd(input int d, input int unsigned ch);
    s_ren[d] = 1'b1; s_rch[d] = ch;
  endtask

  task automatic clear_stim();
    for (int d = 0; d < 2; d++) begin
      s_wen[d] = 1'b0; s_ren[d] = 1'b0; s_clr[d] = 1'b0;
      s_wch[d] = 0; s_rch[d] = 0; s_wd[d] = 8'h00;
    end
  endtask

  task automatic drive();
    a_wr_en = s_wen[0]; a_wr_ch = 2'(s_wch[0]); a_wr_data = s_wd[0];
    a_rd_en = s_ren[0]; a_rd_ch = 2'(s_rch[0]); a_flag_clr = s_clr[0];
    b_wr_en = s_wen[1]; b_wr_ch = 3'(s_wch[1]); b_wr_data = s_wd[1];
    b_rd_en = s_ren[1]; b_rd_ch = 3'(s_rch[1]); b_flag_clr = s_clr[1];
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 5; c++) begin
        q[d][c].delete();
        m_ovf[d][c] = 1'b0; m_unf[d][c] = 1'b0; m_wm[d][c] = 0;
      end
      m_cerr[d] = 1'b0;
    end
    m_rv = 1'b0; m_rd = 8'h00;
  endtask

  // Apply one clock edge of instance d to the model, from the driven stimulus.
  task automatic model_step(input int d);
    int unsigned n, wsz, rsz, post;
    int unsigned pre[5];
    bit wleg, rleg, wok, rok, cerr_new, o, u;
    logic [7:0] pd;
    n = nch(d);
    pd = 8'h00;
    wleg = s_wch[d] < n;
    rleg = s_rch[d] < n;
    wsz = wleg ? q[d][s_wch[d]].size() : 0;
    rsz = rleg ? q[d][s_rch[d]].size() : 0;
    wok = s_wen[d] && wleg && (wsz < dep(d));
    rok = s_ren[d] && rleg && (rsz > 0);
    cerr_new = (s_wen[d] && !wleg) || (s_ren[d] && !rleg);
    for (int c = 0; c < 5; c++) pre[c] = q[d][c].size();
    if (rok) pd = q[d][s_rch[d]].pop_front();
    if (wok) q[d][s_wch[d]].push_back(s_wd[d]);
    for (int unsigned c = 0; c < n; c++) begin
      o = s_wen[d] && wleg && (s_wch[d] == c) && (wsz == dep(d));
      u = s_ren[d] && rleg && (s_rch[d] == c) && (rsz == 0);
      post = q[d][c].size();
      if (s_clr[d]) begin
        m_ovf[d][c] = o; m_unf[d][c] = u;
        m_wm[d][c] = (post > pre[c]) ? post : pre[c];
      end else begin
        m_ovf[d][c] = m_ovf[d][c] | o; m_unf[d][c] = m_unf[d][c] | u;
        if (post > m_wm[d][c]) m_wm[d][c] = post;
      end
    end
    m_cerr[d] = s_clr[d] ? cerr_new : (m_cerr[d] | cerr_new);
    if (d == 1) begin
      m_rv = rok;
      if (rok) m_rd = pd;
    end
  endtask

  task automatic check_dut(input int d);
    logic [4:0]  g_full, g_empty, g_af, g_ae, g_ovf, g_unf;
    logic [14:0] g_cnt;
    logic        g_cerr, g_rv;
    logic [7:0]  g_rd;
    string       p;
    int unsigned sz;
    bit          ev;
`ifdef SYNC_MC_FIFO_WATERMARK_EN
    logic [14:0] g_wm;
`endif
    if (d == 0) begin
      p = "A";
      g_full = {1'b0, a_full}; g_empty = {1'b0, a_empty}; g_af = {1'b0, a_af};
      g_ae = {1'b0, a_ae}; g_ovf = {1'b0, a_ovf}; g_unf = {1'b0, a_unf};
      g_cnt = {3'b000, a_cnt}; g_cerr = a_ch_err; g_rv = a_rd_valid; g_rd = a_rd_data;
`ifdef SYNC_MC_FIFO_WATERMARK_EN
      g_wm = {3'b000, a_wm};
`endif
    end else begin
      p = "B";
      g_full = b_full; g_empty = b_empty; g_af = b_af; g_ae = b_ae;
      g_ovf = b_ovf; g_unf = b_unf; g_cnt = b_cnt; g_cerr = b_ch_err;
      g_rv = b_rd_valid; g_rd = b_rd_data;
`ifdef SYNC_MC_FIFO_WATERMARK_EN
      g_wm = b_wm;
`endif
    end
    for (int unsigned c = 0; c < nch(d); c++) begin
      sz = q[d][c].size();
      check($sformatf("%s full[%0d]", p, c),  32'(g_full[c]),  32'(sz == dep(d)));
      check($sformatf("%s empty[%0d]", p, c), 32'(g_empty[c]), 32'(sz == 0));
      check($sformatf("%s afull[%0d]", p, c), 32'(g_af[c]),    32'(sz >= afl(d)));
      check($sformatf("%s aempty[%0d]", p, c), 32'(g_ae[c]),   32'(sz <= ael(d)));
      check($sformatf("%s cnt[%0d]", p, c),   32'(g_cnt[c*3 +: 3]), sz);
      check($sformatf("%s overflow[%0d]", p, c),  32'(g_ovf[c]), 32'(m_ovf[d][c]));
      check($sformatf("%s underflow[%0d]", p, c), 32'(g_unf[c]), 32'(m_unf[d][c]));
`ifdef SYNC_MC_FIFO_WATERMARK_EN
      check($sformatf("%s watermark[%0d]", p, c), 32'(g_wm[c*3 +: 3]), m_wm[d][c]);
`endif
    end
    check({p, " ch_err"}, 32'(g_cerr), 32'(m_cerr[d]));
    if (d == 0) begin
      ev = (s_rch[0] < 4) && (q[0][s_rch[0]].size() > 0);
      check("A rd_valid", 32'(g_rv), 32'(ev));
      if (ev) check("A rd_data", 32'(g_rd), 32'(q[0][s_rch[0]][0]));
    end else begin
      check("B rd_valid", 32'(g_rv), 32'(m_rv));
      check("B rd_data", 32'(g_rd), 32'(m_rd));
    end
  endtask

  // One clock: drive after the falling edge, check mid-cycle, then let the
  // model take the rising edge.
  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    clear_stim();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_stim();
    drive();
    rst = 1'b1;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_cycle(input int unsigned wpct, input int unsigned rpct);
    int unsigned n;
    for (int d = 0; d < 2; d++) begin
      n = nch(d);
      s_wen[d] = $urandom_range(0, 99) < wpct;
      s_wch[d] = (d == 1 && $urandom_range(0, 19) == 0) ? $urandom_range(5, 7) : $urandom_range(0, n - 1);
      s_wd[d]  = 8'($urandom);
      s_ren[d] = $urandom_range(0, 99) < rpct;
      s_rch[d] = (d == 1 && $urandom_range(0, 19) == 0) ? $urandom_range(5, 7) : $urandom_range(0, n - 1);
      s_clr[d] = $urandom_range(0, 39) == 0;
    end
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    clear_stim();
    drive();
    model_reset();
    do_reset();

    // A: fill ch2, overflow it, drain in order.
    for (int i = 0; i < 6; i++) begin
      set_wr(0, 2, 8'(8'h10 + i));
      cycle();
    end
    check("A cnt2 after 6 writes", 32'(a_cnt[8:6]), 32'd6);
    check("A full2 after 6 writes", 32'(a_full[2]), 32'd1);
    check("A other channels empty", 32'(a_empty), 32'hB);
    set_wr(0, 2, 8'h16);
    cycle();
    check("A overflow2 after 7th write", 32'(a_ovf[2]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      set_rd(0, 2);
      if (i == 0) begin
        @(negedge clk); drive(); #1;
        check("A first head ch2", 32'(a_rd_data), 32'h10);
        clear_stim(); set_rd(0, 2);
        // Re-sync to the cycle boundary used by cycle().
        @(posedge clk); model_step(0); model_step(1); clear_stim(); #1;
      end else begin
        cycle();
      end
    end
    check("A underflow2 after drain", 32'(a_unf[2]), 32'd0);

    // A: empty ch1 write+read same cycle.
    set_wr(0, 1, 8'h77);
    set_rd(0, 1);
    // B: load 0xA5 into ch0 in parallel.
    set_wr(1, 0, 8'hA5);
    cycle();
    check("A cnt1 after wr+rd on empty", 32'(a_cnt[5:3]), 32'd1);
    check("A underflow1 after wr+rd on empty", 32'(a_unf[1]), 32'd1);
    s_clr[0] = 1'b1;
    set_rd(1, 0);
    cycle();
    check("A underflow1 after flag_clr", 32'(a_unf[1]), 32'd0);
    check("B rd_valid one cycle after read", 32'(b_rd_valid), 32'd1);
    check("B rd_data one cycle after read", 32'(b_rd_data), 32'hA5);

    // B: illegal read channel.
    set_rd(1, 5);
    cycle();
    check("B ch_err on rd_ch=5", 32'(b_ch_err), 32'd1);
    check("B cnt unchanged on rd_ch=5", 32'(b_cnt), 32'd0);

    // B: fill ch0 to 4 then drain.
    for (int i = 0; i < 4; i++) begin set_wr(1, 0, 8'(i)); cycle(); end
    for (int i = 0; i < 4; i++) begin set_rd(1, 0); cycle(); end
`ifdef SYNC_MC_FIFO_WATERMARK_EN
    check("B watermark0 after fill/drain", 32'(b_wm[2:0]), 32'd4);
`endif

    // A: interleave ch0/ch3, wrapping each channel twice.
    for (int i = 0; i < 28; i++) begin
      set_wr(0, (i % 2) ? 3 : 0, 8'(8'h40 + i));
      if (i >= 4) set_rd(0, (i % 2) ? 3 : 0);
      cycle();
    end

    // Random traffic, write-biased then read-biased, with a reset mid-burst.
    for (int i = 0; i < 250; i++) rand_cycle(70, 35);
    do_reset();
    for (int i = 0; i < 150; i++) rand_cycle(75, 30);
    for (int i = 0; i < 200; i++) rand_cycle(35, 70);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
